// File: rtl/axim_pkg.sv
// Shared definitions for the AXI4 master write path: FSM states,
// AXI burst/response encodings and the 4KB page-boundary constant.
package axim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI bursts must never cross a 4KB address page.
  localparam int unsigned AXI_4KB = 4096;

endpackage

// File: rtl/axim_len_fifo.sv
// Small FIFO holding awlen (beats-1) of every issued AW burst so the W
// path knows where each burst ends. Pointers wrap explicitly, so DEPTH
// need not be a power of two.
module axim_len_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axim_wr_ctrl.sv
// AXI4 master write controller: splits a byte transfer into INCR bursts
// (bounded by C_MAX_BURST_LEN and 4KB pages), streams data from a
// valid/ready source onto W, and tracks outstanding B responses.
// Optional: define AXIM_WR_BRESP_CHECK_EN to add the sticky ctrl_werr_o.
module axim_wr_ctrl
  import axim_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned C_MAX_BURST_LEN    = 16,
  parameter int unsigned C_MAX_OUTSTANDING  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ctrl_waddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_wxfer_size_i,
  input  logic                            ctrl_wstart_i,
  output logic                            ctrl_wdone_o,
  output logic                            ctrl_wbusy_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_tdata_i,
  input  logic                            wr_tvalid_i,
  output logic                            wr_tready_o,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  input  logic [1:0]                      m_axi_bresp
`ifdef AXIM_WR_BRESP_CHECK_EN
  ,
  output logic                            ctrl_werr_o
`endif
);

  localparam int unsigned AW       = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned XW       = C_XFER_SIZE_WIDTH;
  localparam int unsigned BPB      = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned LOG2_BPB = $clog2(BPB);
  localparam int unsigned CNT_W    = $clog2(C_MAX_OUTSTANDING + 1);

  wr_state_t        state;
  logic [AW-1:0]    addr;
  logic [XW-1:0]    beats_rem;
  logic [CNT_W-1:0] outstanding;
  logic [7:0]       wcnt;

  logic [XW:0]      size_ext;
  logic [XW-1:0]    beats_init;
  logic [12:0]      bytes_to_4k;
  logic [12:0]      beats_to_4k;
  logic [8:0]       burst_beats;
  logic [7:0]       burst_len;

  logic             start_acc;
  logic             slot_ok;
  logic             issuing;
  logic             aw_hs;
  logic             w_act;
  logic             wlast_int;
  logic             w_hs;
  logic             b_hs;

  logic [7:0]       head_len;
  logic             fifo_empty;
  logic             fifo_full;

  assign start_acc   = ctrl_wstart_i && (state == ST_IDLE) && !rst;
  assign size_ext    = {1'b0, ctrl_wxfer_size_i} + (XW+1)'(BPB - 1);
  assign beats_init  = XW'(size_ext >> LOG2_BPB);

  // addr is beat-aligned, so the byte distance to the page end divides evenly.
  assign bytes_to_4k = 13'(AXI_4KB) - {1'b0, addr[11:0]};
  assign beats_to_4k = bytes_to_4k >> LOG2_BPB;

  // Burst length: smallest of configured max, page remainder and beats left.
  always_comb begin
    burst_beats = 9'(C_MAX_BURST_LEN);
    if (beats_to_4k < 13'(burst_beats)) begin
      burst_beats = beats_to_4k[8:0];
    end
    if (beats_rem < XW'(burst_beats)) begin
      burst_beats = beats_rem[8:0];
    end
  end

  assign burst_len = 8'(burst_beats - 9'd1);
  assign issuing   = (state == ST_ISSUE) && !rst;
  assign slot_ok   = (outstanding < CNT_W'(C_MAX_OUTSTANDING)) && !fifo_full;
  assign aw_hs     = m_axi_awvalid && m_axi_awready;

  // AW fields derive only from addr/beats_rem, which move solely on a
  // handshake, so they stay stable while awvalid waits for awready.
  assign m_axi_awvalid = issuing && slot_ok;
  assign m_axi_awaddr  = issuing ? addr : '0;
  assign m_axi_awlen   = issuing ? burst_len : '0;
  assign m_axi_awsize  = 3'(LOG2_BPB);
  assign m_axi_awburst = AXI_BURST_INCR;

  // W only runs for bursts whose AW has already been pushed.
  assign w_act        = !fifo_empty && !rst;
  assign wlast_int    = w_act && (wcnt == head_len);
  assign m_axi_wdata  = wr_tdata_i;
  assign m_axi_wvalid = wr_tvalid_i && w_act;
  assign wr_tready_o  = m_axi_wready && w_act;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = wlast_int;
  assign w_hs         = m_axi_wvalid && m_axi_wready;

  assign m_axi_bready = ((state == ST_ISSUE) || (state == ST_DRAIN)) && !rst;
  assign b_hs         = m_axi_bvalid && m_axi_bready;

  assign ctrl_wdone_o = (state == ST_DONE) && !rst;
  assign ctrl_wbusy_o = (state != ST_IDLE) && !rst;

  axim_len_fifo #(
    .DEPTH (C_MAX_OUTSTANDING),
    .WIDTH (8)
  ) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (aw_hs),
    .din_i   (burst_len),
    .pop_i   (w_hs && wlast_int),
    .dout_o  (head_len),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Main FSM with address / remaining-beat bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      beats_rem <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_wstart_i) begin
            addr      <= ctrl_waddr_offset_i & ~AW'(BPB - 1);
            beats_rem <= beats_init;
            state     <= (ctrl_wxfer_size_i == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (aw_hs) begin
            addr      <= addr + (AW'(burst_beats) << LOG2_BPB);
            beats_rem <= beats_rem - XW'(burst_beats);
            if (beats_rem == XW'(burst_beats)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((outstanding == '0) && fifo_empty) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding AW bursts awaiting B; simultaneous AW and B cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= (outstanding != '0) ? outstanding - CNT_W'(1) : outstanding;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Beat counter within the head-of-FIFO burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (w_hs) begin
      wcnt <= wlast_int ? '0 : wcnt + 8'd1;
    end
  end

`ifdef AXIM_WR_BRESP_CHECK_EN
  logic werr;

  // Sticky error flag for any non-OKAY response, cleared by a new start.
  always_ff @(posedge clk) begin
    if (rst) begin
      werr <= 1'b0;
    end else if (start_acc) begin
      werr <= 1'b0;
    end else if (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) begin
      werr <= 1'b1;
    end
  end

  assign ctrl_werr_o = werr;
`else
  logic unused_bresp;
  logic unused_start;
  assign unused_bresp = ^m_axi_bresp;
  assign unused_start = start_acc;
`endif

endmodule

// File: tb/tb_axim_wr_ctrl.sv
// Directed bench for axim_wr_ctrl: a behavioural AXI slave and stream
// source live in the tick task; checks are immediate assertions.
module tb_axim_wr_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_waddr_offset_i;
  logic [31:0] ctrl_wxfer_size_i;
  logic        ctrl_wstart_i;
  logic        ctrl_wdone_o;
  logic        ctrl_wbusy_o;
  logic [31:0] wr_tdata_i;
  logic        wr_tvalid_i;
  logic        wr_tready_o;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
`ifdef AXIM_WR_BRESP_CHECK_EN
  logic        ctrl_werr_o;
`endif

  axim_wr_ctrl #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_XFER_SIZE_WIDTH  (32),
    .C_MAX_BURST_LEN    (16),
    .C_MAX_OUTSTANDING  (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ctrl_waddr_offset_i (ctrl_waddr_offset_i),
    .ctrl_wxfer_size_i   (ctrl_wxfer_size_i),
    .ctrl_wstart_i       (ctrl_wstart_i),
    .ctrl_wdone_o        (ctrl_wdone_o),
    .ctrl_wbusy_o        (ctrl_wbusy_o),
    .wr_tdata_i          (wr_tdata_i),
    .wr_tvalid_i         (wr_tvalid_i),
    .wr_tready_o         (wr_tready_o),
    .m_axi_awvalid       (m_axi_awvalid),
    .m_axi_awready       (m_axi_awready),
    .m_axi_awaddr        (m_axi_awaddr),
    .m_axi_awlen         (m_axi_awlen),
    .m_axi_awsize        (m_axi_awsize),
    .m_axi_awburst       (m_axi_awburst),
    .m_axi_wvalid        (m_axi_wvalid),
    .m_axi_wready        (m_axi_wready),
    .m_axi_wdata         (m_axi_wdata),
    .m_axi_wstrb         (m_axi_wstrb),
    .m_axi_wlast         (m_axi_wlast),
    .m_axi_bvalid        (m_axi_bvalid),
    .m_axi_bready        (m_axi_bready),
    .m_axi_bresp         (m_axi_bresp)
`ifdef AXIM_WR_BRESP_CHECK_EN
    ,
    .ctrl_werr_o         (ctrl_werr_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Bench-side slave / source state
  bit          rnd_mode = 0;
  bit          wr_en    = 1;
  bit          b_en     = 1;
  bit          start_req = 0;
  int          b_pend   = 0;
  int          src_idx  = 0;
  int          src_base = 0;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] w_q[$];
  int          wlast_q[$];
  int          aw_beats = 0;
  int          w_total  = 0;
  int          b_cnt    = 0;
  int          done_cnt = 0;
  int          order_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, then log the handshakes
  // that the next rising edge will complete.
  task automatic tick();
    @(negedge clk);
    ctrl_wstart_i = start_req;
    start_req = 0;
    if (rnd_mode) begin
      wr_tvalid_i  = 1'($urandom_range(0, 1));
      m_axi_wready = 1'($urandom_range(0, 1));
    end else begin
      wr_tvalid_i  = 1'b1;
      m_axi_wready = wr_en;
    end
    wr_tdata_i   = 32'hA000_0000 + 32'(src_idx);
    m_axi_bvalid = b_en && (b_pend != 0);
    #1;
    if (!rst) begin
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_total >= aw_beats) order_err++;
        w_q.push_back(m_axi_wdata);
        w_total++;
        if (m_axi_wlast) begin
          wlast_q.push_back(w_total);
          b_pend++;
        end
      end
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_q.push_back(m_axi_awaddr);
        aw_len_q.push_back(m_axi_awlen);
        aw_beats += int'(m_axi_awlen) + 1;
      end
      if (wr_tvalid_i && wr_tready_o) src_idx++;
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend--;
        b_cnt++;
      end
      if (ctrl_wdone_o) done_cnt++;
    end
  endtask

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_len_q.delete();
    w_q.delete();
    wlast_q.delete();
    aw_beats  = 0;
    w_total   = 0;
    b_cnt     = 0;
    done_cnt  = 0;
    order_err = 0;
    src_base  = src_idx;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] sz);
    clear_logs();
    ctrl_waddr_offset_i = a;
    ctrl_wxfer_size_i   = sz;
    start_req = 1;
    tick();
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(done_cnt), 64'd1);
    repeat (3) tick();
    chk({tag, "_single"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic chk_data(input string tag, input int n);
    chk({tag, "_wcount"}, 64'(w_q.size()), 64'(n));
    for (int i = 0; i < n && i < w_q.size(); i++) begin
      chk({tag, "_wdata"}, 64'(w_q[i]), 64'(32'hA000_0000 + 32'(src_base + i)));
    end
    chk({tag, "_order"}, 64'(order_err), 64'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
    chk({tag, "_wvalid"},  64'(m_axi_wvalid),  64'd0);
    chk({tag, "_wlast"},   64'(m_axi_wlast),   64'd0);
    chk({tag, "_bready"},  64'(m_axi_bready),  64'd0);
    chk({tag, "_wdone"},   64'(ctrl_wdone_o),  64'd0);
    chk({tag, "_busy"},    64'(ctrl_wbusy_o),  64'd0);
    chk({tag, "_tready"},  64'(wr_tready_o),   64'd0);
    chk({tag, "_awaddr"},  64'(m_axi_awaddr),  64'd0);
    chk({tag, "_awlen"},   64'(m_axi_awlen),   64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    ctrl_waddr_offset_i = '0;
    ctrl_wxfer_size_i   = '0;
    ctrl_wstart_i       = 1'b0;
    wr_tdata_i          = '0;
    wr_tvalid_i         = 1'b0;
    m_axi_awready       = 1'b1;
    m_axi_wready        = 1'b0;
    m_axi_bvalid        = 1'b0;
    m_axi_bresp         = 2'b00;

    // Reset state
    repeat (3) tick();
    chk_idle_outputs("reset");
    chk("awsize", 64'(m_axi_awsize), 64'd2);
    chk("awburst", 64'(m_axi_awburst), 64'd1);
    chk("wstrb", 64'(m_axi_wstrb), 64'hF);
    rst = 1'b0;
    tick();

    // Single 8-beat burst
    start(32'h4000_0000, 32'd32);
    run_until_done("t1_done", 200);
    chk("t1_awcount", 64'(aw_addr_q.size()), 64'd1);
    chk("t1_awaddr", 64'(aw_addr_q[0]), 64'h4000_0000);
    chk("t1_awlen", 64'(aw_len_q[0]), 64'd7);
    chk("t1_wlast_cnt", 64'(wlast_q.size()), 64'd1);
    chk("t1_wlast_pos", 64'(wlast_q[0]), 64'd8);
    chk("t1_bcount", 64'(b_cnt), 64'd1);
    chk_data("t1", 8);

    // 4KB boundary split
    start(32'h4000_0FF0, 32'd64);
    run_until_done("t2_done", 200);
    chk("t2_awcount", 64'(aw_addr_q.size()), 64'd2);
    chk("t2_awaddr0", 64'(aw_addr_q[0]), 64'h4000_0FF0);
    chk("t2_awlen0", 64'(aw_len_q[0]), 64'd3);
    chk("t2_awaddr1", 64'(aw_addr_q[1]), 64'h4000_1000);
    chk("t2_awlen1", 64'(aw_len_q[1]), 64'd11);
    chk("t2_wlast0", 64'(wlast_q[0]), 64'd4);
    chk("t2_wlast1", 64'(wlast_q[1]), 64'd16);
    chk_data("t2", 16);

    // 256 bytes, B held off: 4 AWs then wait in DRAIN
    b_en = 0;
    start(32'h4000_0000, 32'd256);
    repeat (40) tick();
    chk("t3_awcount_hold", 64'(aw_addr_q.size()), 64'd4);
    chk("t3_nodone_hold", 64'(done_cnt), 64'd0);
    chk("t3_busy_hold", 64'(ctrl_wbusy_o), 64'd1);
    chk("t3_bready_hold", 64'(m_axi_bready), 64'd1);
    b_en = 1;
    run_until_done("t3_done", 200);
    chk("t3_bcount", 64'(b_cnt), 64'd4);
    chk_data("t3", 64);

    // 512 bytes, B held off: outstanding limit stalls AW at 4
    b_en = 0;
    start(32'h4000_0000, 32'd512);
    repeat (60) tick();
    chk("t3b_awcount_stall", 64'(aw_addr_q.size()), 64'd4);
    chk("t3b_awvalid_stall", 64'(m_axi_awvalid), 64'd0);
    b_en = 1;
    run_until_done("t3b_done", 400);
    chk("t3b_awcount", 64'(aw_addr_q.size()), 64'd8);
    chk("t3b_awaddr4", 64'(aw_addr_q[4]), 64'h4000_0100);
    chk("t3b_bcount", 64'(b_cnt), 64'd8);

    // Zero-size transfer
    start(32'h4000_0000, 32'd0);
    chk("t4_wdone_t0", 64'(ctrl_wdone_o), 64'd0);
    tick();
    chk("t4_wdone_t1", 64'(ctrl_wdone_o), 64'd1);
    chk("t4_busy_t1", 64'(ctrl_wbusy_o), 64'd1);
    tick();
    chk("t4_wdone_t2", 64'(ctrl_wdone_o), 64'd0);
    chk("t4_busy_t2", 64'(ctrl_wbusy_o), 64'd0);
    chk("t4_awcount", 64'(aw_addr_q.size()), 64'd0);
    chk("t4_wcount", 64'(w_q.size()), 64'd0);

    // Random valid/ready, 32 beats
    rnd_mode = 1;
    start(32'h4000_2000, 32'd128);
    run_until_done("t5_done", 2000);
    rnd_mode = 0;
    chk("t5_awcount", 64'(aw_addr_q.size()), 64'd2);
    chk("t5_wlast0", 64'(wlast_q[0]), 64'd16);
    chk("t5_wlast1", 64'(wlast_q[1]), 64'd32);
    chk_data("t5", 32);

    // Reset during the second burst, then a fresh transfer
    start(32'h4000_3000, 32'd128);
    n = 0;
    while (w_total < 18 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_reached_burst2", 64'(w_total >= 18), 64'd1);
    rst = 1'b1;
    tick();
    chk_idle_outputs("t6_rst");
    tick();
    chk("t6_nodone", 64'(done_cnt), 64'd0);
    rst = 1'b0;
    b_pend = 0;
    tick();
    chk("t6_idle_after", 64'(ctrl_wbusy_o), 64'd0);
    start(32'h4000_4000, 32'd32);
    run_until_done("t6_done", 200);
    chk("t6_awcount", 64'(aw_addr_q.size()), 64'd1);
    chk("t6_awaddr", 64'(aw_addr_q[0]), 64'h4000_4000);
    chk("t6_awlen", 64'(aw_len_q[0]), 64'd7);
    chk_data("t6", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
